// File: rtl/lcd_char_refresher.sv
// lcd_char_refresher
// Shadow character buffer (LINES x CHARS) with per-cell dirty bits. Only
// cells whose content changed are rewritten on an HD44780-style 8-bit bus.
// Set-address commands are skipped when the LCD's auto-incremented cursor
// already points at the next dirty cell.
// Optional feature macro: LCD_BUSY_POLL_EN. When defined, the fixed post-
// transaction wait is replaced by busy-flag reads with a timeout.
module lcd_char_refresher #(
    parameter int LINES = 4,
    parameter int CHARS = 20,
    parameter logic [0:LINES-1][6:0] LINE_STARTS = {7'h00, 7'h40, 7'h14, 7'h54},
    parameter int SETUP_CYC  = 2,
    parameter int E_HIGH_CYC = 12,
    parameter int HOLD_CYC   = 2,
    parameter int EXEC_CYC   = 2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       initilized,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [1:0] wr_line,
    input  logic [5:0] wr_col,
    input  logic [7:0] wr_char,
    output logic       wr_err,
    output logic       busy,
    output logic       RS,
    output logic       RW,
    output logic       E,
    output logic [7:0] DATA_OUT,
    output logic       DATA_OE,
    input  logic [7:0] DATA_IN
);

    localparam int NCELLS = LINES * CHARS;
    localparam int IW     = (NCELLS > 1) ? $clog2(NCELLS) : 1;

    localparam logic [31:0] SETUP_CNT = 32'(SETUP_CYC - 1);
    localparam logic [31:0] E_CNT     = 32'(E_HIGH_CYC - 1);
    localparam logic [31:0] HOLD_CNT  = 32'(HOLD_CYC - 1);
`ifdef LCD_BUSY_POLL_EN
    localparam logic [31:0] TMO_LAST  = 32'(4 * EXEC_CYC - 1);
`else
    localparam logic [31:0] EXEC_CNT  = 32'(EXEC_CYC - 1);
`endif

    typedef enum logic [3:0] {
        IDLE, SCAN,
        CMD_SETUP, CMD_E, CMD_HOLD, CMD_WAIT,
        DAT_SETUP, DAT_E, DAT_HOLD, DAT_WAIT
    } state_t;

    state_t            state;
    logic [7:0]        cells [NCELLS];
    logic [NCELLS-1:0] dirty;
    logic [1:0]        scan_line;
    logic [5:0]        scan_col;
    logic [IW-1:0]     scan_idx;
    logic [IW-1:0]     wr_idx;
    logic [6:0]        scan_addr;
    logic [6:0]        cap_addr;
    logic [7:0]        cap_char;
    logic [6:0]        cursor;
    logic              cursor_valid;
    logic [31:0]       cnt;
    logic              wr_in_range;
    logic              wr_fire;
    logic              capture;
    logic              wait_done;

`ifdef LCD_BUSY_POLL_EN
    logic [1:0]        poll_phase;
    logic              poll_flag;
    logic [31:0]       tmo;

    assign wait_done = (poll_phase == 2'd2) && (cnt == '0) &&
                       (!poll_flag || (tmo >= TMO_LAST));
`else
    logic              unused_data_in;

    assign unused_data_in = ^DATA_IN;
    assign wait_done      = (cnt == '0);
`endif

    assign scan_idx    = IW'(int'(scan_line) * CHARS + int'(scan_col));
    assign wr_idx      = IW'(int'(wr_line) * CHARS + int'(wr_col));
    assign scan_addr   = LINE_STARTS[scan_line] + {1'b0, scan_col};
    assign wr_in_range = (int'(wr_line) < LINES) && (int'(wr_col) < CHARS);
    assign capture     = (state == SCAN) && initilized && dirty[scan_idx];
    assign wr_ready    = !reset && !capture;
    assign wr_fire     = wr_valid && wr_ready;
    assign busy        = !reset && ((|dirty) || !((state == IDLE) || (state == SCAN)));

    // Shadow buffer: store changed characters, track dirty cells, flag bad writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCELLS; i++) begin
                cells[i] <= 8'h20;
            end
            dirty  <= '1;
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_fire && !wr_in_range;
            if (capture) begin
                dirty[scan_idx] <= 1'b0;
            end
            if (wr_fire && wr_in_range && (cells[wr_idx] != wr_char)) begin
                cells[wr_idx] <= wr_char;
                dirty[wr_idx] <= 1'b1;
            end
        end
    end

    // Scan and bus sequencer: find dirty cells and drive timed LCD transactions.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            scan_line    <= '0;
            scan_col     <= '0;
            cursor       <= '0;
            cursor_valid <= 1'b0;
            cap_char     <= '0;
            cap_addr     <= '0;
            cnt          <= '0;
            RS           <= 1'b0;
            RW           <= 1'b0;
            E            <= 1'b0;
            DATA_OUT     <= '0;
            DATA_OE      <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
            poll_phase   <= '0;
            poll_flag    <= 1'b0;
            tmo          <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    cursor_valid <= 1'b0;
                    if (initilized) begin
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (!initilized) begin
                        state        <= IDLE;
                        cursor_valid <= 1'b0;
                    end else begin
                        if (int'(scan_col) == CHARS - 1) begin
                            scan_col  <= '0;
                            scan_line <= (int'(scan_line) == LINES - 1) ? 2'd0 : scan_line + 2'd1;
                        end else begin
                            scan_col <= scan_col + 6'd1;
                        end
                        if (dirty[scan_idx]) begin
                            cap_char <= cells[scan_idx];
                            cap_addr <= scan_addr;
                            DATA_OE  <= 1'b1;
                            RW       <= 1'b0;
                            cnt      <= SETUP_CNT;
                            if (cursor_valid && (cursor == scan_addr)) begin
                                state    <= DAT_SETUP;
                                RS       <= 1'b1;
                                DATA_OUT <= cells[scan_idx];
                            end else begin
                                state    <= CMD_SETUP;
                                RS       <= 1'b0;
                                DATA_OUT <= {1'b1, scan_addr};
                            end
                        end
                    end
                end
                CMD_SETUP, DAT_SETUP: begin
                    if (cnt == '0) begin
                        E     <= 1'b1;
                        cnt   <= E_CNT;
                        state <= (state == CMD_SETUP) ? CMD_E : DAT_E;
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                CMD_E, DAT_E: begin
                    if (cnt == '0) begin
                        E     <= 1'b0;
                        cnt   <= HOLD_CNT;
                        state <= (state == CMD_E) ? CMD_HOLD : DAT_HOLD;
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                CMD_HOLD, DAT_HOLD: begin
                    if (cnt == '0) begin
                        RS      <= 1'b0;
                        DATA_OE <= 1'b0;
                        state   <= (state == CMD_HOLD) ? CMD_WAIT : DAT_WAIT;
`ifdef LCD_BUSY_POLL_EN
                        RW         <= 1'b1;
                        poll_phase <= 2'd0;
                        cnt        <= SETUP_CNT;
                        tmo        <= '0;
`else
                        cnt     <= EXEC_CNT;
`endif
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                CMD_WAIT, DAT_WAIT: begin
                    if (wait_done) begin
                        RW <= 1'b0;
                        E  <= 1'b0;
                        if (state == CMD_WAIT) begin
                            state    <= DAT_SETUP;
                            RS       <= 1'b1;
                            DATA_OE  <= 1'b1;
                            DATA_OUT <= cap_char;
                            cnt      <= SETUP_CNT;
                        end else begin
                            cursor       <= cap_addr + 7'd1;
                            cursor_valid <= initilized;
                            state        <= initilized ? SCAN : IDLE;
                        end
                    end else begin
`ifdef LCD_BUSY_POLL_EN
                        tmo <= tmo + 32'd1;
                        case (poll_phase)
                            2'd0: begin
                                if (cnt == '0) begin
                                    E          <= 1'b1;
                                    cnt        <= E_CNT;
                                    poll_phase <= 2'd1;
                                end else begin
                                    cnt <= cnt - 32'd1;
                                end
                            end
                            2'd1: begin
                                if (cnt == '0) begin
                                    E          <= 1'b0;
                                    poll_flag  <= DATA_IN[7];
                                    cnt        <= HOLD_CNT;
                                    poll_phase <= 2'd2;
                                end else begin
                                    cnt <= cnt - 32'd1;
                                end
                            end
                            default: begin
                                if (cnt == '0) begin
                                    cnt        <= SETUP_CNT;
                                    poll_phase <= 2'd0;
                                end else begin
                                    cnt <= cnt - 32'd1;
                                end
                            end
                        endcase
`else
                        cnt <= cnt - 32'd1;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_char_refresher.sv
// tb_lcd_char_refresher
// Directed bench for lcd_char_refresher (default build, busy polling off).
// Expected bus transactions are queued when stimulus is applied and popped
// by a bus monitor on each falling edge of E.
module tb_lcd_char_refresher;

    localparam int LINES = 4;
    localparam int CHARS = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       initilized = 1'b0;
    logic       wr_valid = 1'b0;
    logic [1:0] wr_line = '0;
    logic [5:0] wr_col = '0;
    logic [7:0] wr_char = '0;
    logic [7:0] DATA_IN = '0;
    logic       wr_ready;
    logic       wr_err;
    logic       busy;
    logic       RS;
    logic       RW;
    logic       E;
    logic [7:0] DATA_OUT;
    logic       DATA_OE;

    int         total = 0;
    int         bad = 0;
    logic [8:0] exp_q [$];
    logic [6:0] starts [4] = '{7'h00, 7'h40, 7'h14, 7'h54};

    lcd_char_refresher #(
        .LINES(LINES), .CHARS(CHARS),
        .SETUP_CYC(1), .E_HIGH_CYC(2), .HOLD_CYC(1), .EXEC_CYC(4)
    ) dut (
        .clk(clk), .reset(reset), .initilized(initilized),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_line(wr_line),
        .wr_col(wr_col), .wr_char(wr_char), .wr_err(wr_err), .busy(busy),
        .RS(RS), .RW(RW), .E(E), .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE),
        .DATA_IN(DATA_IN)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] line, input logic [5:0] col, input logic [7:0] ch);
        int guard = 0;
        @(negedge clk);
        wr_valid = 1'b1;
        wr_line  = line;
        wr_col   = col;
        wr_char  = ch;
        while (!wr_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("wr_ready_before_accept", {31'b0, wr_ready}, 32'd1);
        @(posedge clk);
        #1 wr_valid = 1'b0;
    endtask

    task automatic pushFullScreen();
        for (int l = 0; l < LINES; l++) begin
            for (int c = 0; c < CHARS; c++) begin
                if (c == 0) exp_q.push_back({1'b0, 1'b1, starts[l]});
                exp_q.push_back({1'b1, 8'h20});
            end
        end
    endtask

    task automatic waitIdle(input string tag, input int budget);
        int n = 0;
        @(negedge clk);
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_busy_low"}, {31'b0, busy}, 32'd0);
        checkOutput({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Bus monitor: measures each E pulse and compares it with the next queued transaction.
    logic       prev_e = 1'b0;
    int         e_cnt = 0;
    logic       m_rs, m_rw, m_oe;
    logic [7:0] m_data;
    logic [8:0] exp_item;
    logic       have_exp;
    always @(negedge clk) begin
        if (reset) begin
            e_cnt  = 0;
            prev_e = 1'b0;
        end else begin
            if (E) begin
                e_cnt++;
                m_rs   = RS;
                m_rw   = RW;
                m_oe   = DATA_OE;
                m_data = DATA_OUT;
            end else if (prev_e) begin
                checkOutput("e_high_width", 32'(e_cnt), 32'd2);
                checkOutput("rw_during_e", {31'b0, m_rw}, 32'd0);
                checkOutput("oe_during_e", {31'b0, m_oe}, 32'd1);
                have_exp = (exp_q.size() != 0);
                checkOutput("txn_was_expected", {31'b0, have_exp}, 32'd1);
                if (have_exp) begin
                    exp_item = exp_q.pop_front();
                    checkOutput("bus_rs_data", {23'b0, m_rs, m_data}, {23'b0, exp_item});
                end
                e_cnt = 0;
            end
            prev_e = E;
        end
    end

    initial begin
        int n;
        $display("[TB] start");

        // Reset state
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_RS", {31'b0, RS}, 32'd0);
        checkOutput("rst_RW", {31'b0, RW}, 32'd0);
        checkOutput("rst_E", {31'b0, E}, 32'd0);
        checkOutput("rst_DATA_OUT", {24'b0, DATA_OUT}, 32'd0);
        checkOutput("rst_DATA_OE", {31'b0, DATA_OE}, 32'd0);
        checkOutput("rst_wr_err", {31'b0, wr_err}, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_wr_ready", {31'b0, wr_ready}, 32'd0);

        // Out of reset, not initialised: dirty screen but no bus activity
        reset = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("preinit_E", {31'b0, E}, 32'd0);
        checkOutput("preinit_DATA_OE", {31'b0, DATA_OE}, 32'd0);
        checkOutput("preinit_busy", {31'b0, busy}, 32'd1);
        checkOutput("preinit_wr_ready", {31'b0, wr_ready}, 32'd1);

        // Full-screen refresh of spaces
        pushFullScreen();
        initilized = 1'b1;
        waitIdle("refresh", 3000);

        // Single cell change needs a set-address command
        exp_q.push_back({1'b0, 8'hC5});
        exp_q.push_back({1'b1, 8'h41});
        applyStimulus(2'd1, 6'd5, 8'h41);
        waitIdle("single", 500);

        // Adjacent cells: second one rides the auto-incremented cursor
        exp_q.push_back({1'b0, 8'h83});
        exp_q.push_back({1'b1, 8'h31});
        exp_q.push_back({1'b1, 8'h32});
        applyStimulus(2'd0, 6'd3, 8'h31);
        applyStimulus(2'd0, 6'd4, 8'h32);
        waitIdle("adjacent", 500);

        // Identical character: nothing to do
        applyStimulus(2'd1, 6'd5, 8'h41);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("same_char_busy", {31'b0, busy}, 32'd0);
        end

        // Out-of-range column
        applyStimulus(2'd0, 6'd25, 8'h55);
        @(negedge clk);
        checkOutput("oor_wr_err_pulse", {31'b0, wr_err}, 32'd1);
        checkOutput("oor_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        checkOutput("oor_wr_err_clear", {31'b0, wr_err}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("oor_no_activity", {31'b0, busy}, 32'd0);
        end

        // Reset while a command strobe is high
        applyStimulus(2'd2, 6'd7, 8'h5A);
        n = 0;
        @(negedge clk);
        while (!(E && !RS) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("found_cmd_e", {31'b0, E}, 32'd1);
        reset = 1'b1;
        initilized = 1'b0;
        @(negedge clk);
        checkOutput("midrst_E", {31'b0, E}, 32'd0);
        checkOutput("midrst_DATA_OE", {31'b0, DATA_OE}, 32'd0);
        checkOutput("midrst_wr_ready", {31'b0, wr_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("postrst_busy", {31'b0, busy}, 32'd1);
        pushFullScreen();
        initilized = 1'b1;
        waitIdle("rerefresh", 3000);

        repeat (20) @(negedge clk);
        checkOutput("final_queue", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
